pulse_counter: RTL and testbench
================================

Name: pulse_counter

Overview:
- Free-running up-counter with clock enable and synchronous clear-to-preset, used as the pulse-length timer in the Morse capture path.
- The capture logic restarts it on every signal edge via sclr, with the count preset to 1.
- It compares cnt against dit/dah/word thresholds, so the count saturates instead of wrapping by default.
- Single clock domain; asynchronous active-low reset.

Parameters:
- W, 8: counter width in bits, 2..32.
- SCLR_VAL, 0: value loaded by synchronous clear; truncated to W bits.
- RST_VAL, 0: value forced by asynchronous reset; truncated to W bits.
- SATURATE, 1: 1 = hold at all-ones, 0 = wrap to 0 after all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; gates every synchronous action.
- sclr  input  1  synchronous clear to SCLR_VAL; acts only when ce=1.
- cnt  output  W  registered count value.
- at_max  output  1  combinational, 1 when cnt == all-ones (2^W-1).

Behaviour:
- Reset (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - rst_n=0 forces cnt=RST_VAL immediately, independent of clk and ce.
  - cnt holds while rst_n=0.
  - at_max follows cnt (1 only if RST_VAL is all-ones).
  - On the first rising clk after rst_n deasserts, normal operation applies.
  - A reset asserted mid-count discards the count; there is no partial state.
- Per rising edge with rst_n=1, priority high to low:
  - ce=0: cnt holds; sclr and all other inputs ignored.
  - ce=1, sclr=1: cnt <= SCLR_VAL, even if the counter is saturated.
  - ce=1, sclr=0, cnt != all-ones: cnt <= cnt+1, modulo 2^W.
  - ce=1, sclr=0, cnt == all-ones:
    - SATURATE=1: cnt holds all-ones.
    - SATURATE=0: cnt <= 0.
- Latency: one clock from sampled ce/sclr to the new cnt. No combinational path from inputs to cnt.
- Arithmetic: unsigned W-bit. SCLR_VAL and RST_VAL are masked to W bits at elaboration.
- at_max is a pure decode of the cnt register, so it carries no extra latency.
- Simultaneous events: sclr wins over increment and over saturation hold. Asynchronous reset wins over everything.
- Inputs are assumed synchronous to clk; no internal synchronisers.

Optional Feature:
- Macro: PULSE_COUNTER_LOAD_EN.
- When defined, adds ports:
  - load  input  1: synchronous parallel load, acts only when ce=1.
  - load_val  input  W: value to load.
- Priority becomes: reset > ce=0 hold > sclr > load > saturate/wrap > increment.
- With ce=1, sclr=0, load=1: cnt <= load_val on the next edge. This applies even when cnt is at max.
- When not defined: the ports do not exist, and behaviour is exactly as above with no load path and no extra logic.

Test Plan:
- Reset with W=8, SCLR_VAL=1, RST_VAL=0:
  - Hold rst_n=0 for 3 clocks with ce=1 -> cnt=0 throughout.
  - Assert rst_n=0 asynchronously mid-cycle while cnt=37 -> cnt=0 before the next edge.
- Count and enable: release reset, ce=1, sclr=0 for 5 edges -> cnt=5. Then ce=0 for 4 edges with sclr=1 -> cnt stays 5.
- Sync clear: at cnt=200, ce=1 and sclr=1 for one edge -> cnt=1. Next 2 edges with sclr=0 -> cnt=3.
- Saturation:
  - SATURATE=1: from cnt=254, 3 edges with ce=1 -> 255, 255, 255; at_max=1 from the first 255.
  - Then sclr=1 for one edge -> cnt=1, at_max=0.
- Wrap: SATURATE=0, W=4, from cnt=14, ce=1 for 3 edges -> 15, 0, 1; at_max=1 only while cnt=15.
- With PULSE_COUNTER_LOAD_EN:
  - cnt=10, ce=1, load=1, load_val=100 -> cnt=100.
  - Same cycle with sclr=1 -> cnt=SCLR_VAL=1.
  - load=1 with ce=0 -> cnt unchanged.

Source files
------------

// File: rtl/pulse_counter.sv
// rtl/pulse_counter.sv - saturating/wrapping pulse-length up-counter (optional load via PULSE_COUNTER_LOAD_EN)
module pulse_counter #(
    parameter int unsigned W        = 8,
    parameter int unsigned SCLR_VAL = 0,
    parameter int unsigned RST_VAL  = 0,
    parameter bit          SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         sclr,
`ifdef PULSE_COUNTER_LOAD_EN
    input  logic         load,
    input  logic [W-1:0] load_val,
`endif
    output logic [W-1:0] cnt,
    output logic         at_max
);

    // Preset values reduced to the counter width once, at elaboration.
    localparam logic [W-1:0] SCLR_W = W'(SCLR_VAL);
    localparam logic [W-1:0] RST_W  = W'(RST_VAL);
    localparam logic [W-1:0] ONE_W  = W'(1);
    localparam logic [W-1:0] ZERO_W = '0;

    // Threshold compare in the capture path keys off this; pure decode, no added latency.
    assign at_max = &cnt;

    // Count register: reset > ce hold > clear > (load) > saturate/wrap > increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_W;
        end else if (ce) begin
            if (sclr) begin
                cnt <= SCLR_W;
`ifdef PULSE_COUNTER_LOAD_EN
            end else if (load) begin
                cnt <= load_val;
`endif
            end else if (at_max) begin
                cnt <= SATURATE ? cnt : ZERO_W;
            end else begin
                cnt <= cnt + ONE_W;
            end
        end
    end

endmodule

// File: tb/tb_pulse_counter.sv
// tb/tb_pulse_counter.sv - self-checking bench for pulse_counter (saturating W=8 and wrapping W=4 instances)
module tb_pulse_counter;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       sclr;
    logic [7:0] cnt;
    logic       at_max;
`ifdef PULSE_COUNTER_LOAD_EN
    logic       load;
    logic [7:0] load_val;
`endif

    logic       rst4_n;
    logic       ce4;
    logic       sclr4;
    logic [3:0] cnt4;
    logic       at_max4;
`ifdef PULSE_COUNTER_LOAD_EN
    logic       load4;
    logic [3:0] load_val4;
`endif

    int tests;
    int fails;

    typedef struct {
        logic       ce;
        logic       sclr;
        logic [7:0] exp_cnt;
        logic       exp_at_max;
    } vec_t;

    vec_t vecs [9];

    pulse_counter #(.W(8), .SCLR_VAL(1), .RST_VAL(0), .SATURATE(1'b1)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .sclr     (sclr),
`ifdef PULSE_COUNTER_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .cnt      (cnt),
        .at_max   (at_max)
    );

    pulse_counter #(.W(4), .SCLR_VAL(1), .RST_VAL(0), .SATURATE(1'b0)) dut4 (
        .clk      (clk),
        .rst_n    (rst4_n),
        .ce       (ce4),
        .sclr     (sclr4),
`ifdef PULSE_COUNTER_LOAD_EN
        .load     (load4),
        .load_val (load_val4),
`endif
        .cnt      (cnt4),
        .at_max   (at_max4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step8(input logic c, input logic s);
        @(negedge clk);
        ce   = c;
        sclr = s;
`ifdef PULSE_COUNTER_LOAD_EN
        load = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic c);
        @(negedge clk);
        ce4 = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        for (int k = 0; k < 5; k++) vecs[k] = '{1'b1, 1'b0, 8'(k + 1), 1'b0};
        for (int k = 5; k < 9; k++) vecs[k] = '{1'b0, 1'b1, 8'd5, 1'b0};

        rst_n  = 1'b0;
        ce     = 1'b1;
        sclr   = 1'b0;
        rst4_n = 1'b0;
        ce4    = 1'b0;
        sclr4  = 1'b0;
`ifdef PULSE_COUNTER_LOAD_EN
        load      = 1'b0;
        load_val  = 8'd0;
        load4     = 1'b0;
        load_val4 = 4'd0;
`endif

        // Reset held with ce=1 for three clocks.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold_cnt", int'(cnt), 0);
        end
        check("reset_at_max", int'(at_max), 0);

        @(negedge clk);
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        ce     = 1'b0;

        // Count five, then hold with sclr ignored under ce=0.
        for (int i = 0; i < 9; i++) begin
            step8(vecs[i].ce, vecs[i].sclr);
            check($sformatf("vec%0d_cnt", i), int'(cnt), int'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_at_max", i), int'(at_max), int'(vecs[i].exp_at_max));
        end

        // Sync clear from 200.
        for (int k = 0; k < 195; k++) step8(1'b1, 1'b0);
        check("reach_200", int'(cnt), 200);
        step8(1'b1, 1'b1);
        check("sclr_from_200", int'(cnt), 1);
        step8(1'b1, 1'b0);
        check("after_sclr_1", int'(cnt), 2);
        step8(1'b1, 1'b0);
        check("after_sclr_2", int'(cnt), 3);

        // Saturation at 255, then clear out of saturation.
        for (int k = 0; k < 251; k++) step8(1'b1, 1'b0);
        check("reach_254", int'(cnt), 254);
        check("at_max_254", int'(at_max), 0);
        for (int k = 0; k < 3; k++) begin
            step8(1'b1, 1'b0);
            check("sat_cnt", int'(cnt), 255);
            check("sat_at_max", int'(at_max), 1);
        end
        step8(1'b1, 1'b1);
        check("sclr_from_sat", int'(cnt), 1);
        check("sclr_from_sat_at_max", int'(at_max), 0);

        // Asynchronous reset mid-cycle at 37.
        for (int k = 0; k < 36; k++) step8(1'b1, 1'b0);
        check("reach_37", int'(cnt), 37);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_cnt", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("after_async_release", int'(cnt), 0);

`ifdef PULSE_COUNTER_LOAD_EN
        // Parallel load and its priority.
        for (int k = 0; k < 10; k++) step8(1'b1, 1'b0);
        check("reach_10", int'(cnt), 10);
        @(negedge clk);
        ce = 1'b1; sclr = 1'b0; load = 1'b1; load_val = 8'd100;
        @(posedge clk); #1;
        check("load_100", int'(cnt), 100);
        @(negedge clk);
        ce = 1'b1; sclr = 1'b1; load = 1'b1; load_val = 8'd77;
        @(posedge clk); #1;
        check("sclr_beats_load", int'(cnt), 1);
        @(negedge clk);
        ce = 1'b0; sclr = 1'b0; load = 1'b1; load_val = 8'd99;
        @(posedge clk); #1;
        check("load_ce0_hold", int'(cnt), 1);
        @(negedge clk);
        load = 1'b0;
`endif

        // Wrapping W=4 instance.
        check("w4_reset", int'(cnt4), 0);
        for (int k = 0; k < 14; k++) step4(1'b1);
        check("w4_reach_14", int'(cnt4), 14);
        check("w4_at_max_14", int'(at_max4), 0);
        step4(1'b1);
        check("w4_cnt_15", int'(cnt4), 15);
        check("w4_at_max_15", int'(at_max4), 1);
        step4(1'b1);
        check("w4_wrap_0", int'(cnt4), 0);
        check("w4_at_max_0", int'(at_max4), 0);
        step4(1'b1);
        check("w4_cnt_1", int'(cnt4), 1);
        check("w4_at_max_1", int'(at_max4), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
